// File: rtl/fb_write_ctrl_pkg.sv
// Shared framebuffer write-path constants, FSM state encoding and pixel type.
package fb_write_ctrl_pkg;

  localparam int FB_FRAME_PIXELS = 16384;
  localparam int FB_PIXEL_BYTES  = 3;
  localparam int FB_ADDR_W       = 15;
  localparam int FB_PIX_W        = 20;

  typedef logic [FB_PIX_W-1:0]  pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OE,
    ST_READ,
    ST_FULL
  } wr_state_t;

endpackage

// File: rtl/fb_write_ctrl_if.sv
// FT232H sync-FIFO read side plus framebuffer write port; master is the write controller.
interface fb_write_ctrl_if;
  import fb_write_ctrl_pkg::*;

  logic       rxf_n;
  logic [7:0] ftdi_data;
  logic       oe_n;
  logic       rd_n;
  pixel_t     wdata;
  fb_addr_t   waddr;
  logic       we;
  logic       full_ftdi;
  logic       swapped_ftdi;

  modport master (
    input  rxf_n, ftdi_data, swapped_ftdi,
    output oe_n, rd_n, wdata, waddr, we, full_ftdi
  );

  modport slave (
    output rxf_n, ftdi_data, swapped_ftdi,
    input  oe_n, rd_n, wdata, waddr, we, full_ftdi
  );

endinterface

// File: rtl/fb_write_ctrl_byte_packer.sv
// Packs 3 sampled bytes into one 20-bit pixel; we/wdata valid the cycle after the 3rd byte.
// No backpressure: every sampled byte is accepted; clear resyncs the byte counter.
module fb_byte_packer
  import fb_write_ctrl_pkg::*;
(
  input  logic       clk_60,
  input  logic       rst_n,
  input  logic       sample,
  input  logic       clear,
  input  logic [7:0] din,
  output logic [1:0] byte_cnt,
  output logic       pixel_done,
  output logic       we,
  output pixel_t     wdata
);

  localparam logic [1:0] LAST_IDX = 2'(FB_PIXEL_BYTES - 1);

  logic [3:0] hi_nib;
  logic [7:0] mid_byte;

  assign pixel_done = sample && (byte_cnt == LAST_IDX);

  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      hi_nib   <= 4'd0;
      mid_byte <= 8'd0;
      we       <= 1'b0;
      wdata    <= '0;
    end else begin
      we <= 1'b0;
      if (sample) begin
        case (byte_cnt)
          2'd0: begin
            // upper nibble of the first byte carries no pixel data
            hi_nib   <= din[3:0];
            byte_cnt <= 2'd1;
          end
          2'd1: begin
            mid_byte <= din;
            byte_cnt <= 2'd2;
          end
          default: begin
            wdata    <= {hi_nib, mid_byte, din};
            we       <= 1'b1;
            byte_cnt <= 2'd0;
          end
        endcase
      end else if (clear) begin
        byte_cnt <= 2'd0;
      end
    end
  end

endmodule

// File: rtl/fb_write_ctrl.sv
// Drains the FT232H stream into sequential back-buffer pixel writes, one pixel per 3 bytes.
// Holds off the FTDI (rd_n/oe_n high) from frame completion until swapped_ftdi.
module fb_write_ctrl
  import fb_write_ctrl_pkg::*;
#(
  parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
  parameter int IDLE_TIMEOUT = 60000
) (
  input  logic                   clk_60,
  input  logic                   rst_n,
  fb_write_ctrl_if.master        bus
);

  localparam int       TO_W      = $clog2(IDLE_TIMEOUT);
  localparam fb_addr_t LAST_ADDR = FB_ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT - 1);

  wr_state_t       state;
  logic            oe_n_q;
  logic            rd_n_q;
  logic            full_q;
  fb_addr_t        waddr_q;
  logic [TO_W-1:0] to_cnt;

  logic       sample;
  logic       pixel_done;
  logic       frame_done;
  logic       busy;
  logic       resync;
  logic       swap;
  logic [1:0] byte_cnt;
  logic       we;
  pixel_t     wdata;

  assign sample     = !bus.rxf_n && !rd_n_q;
  assign frame_done = pixel_done && (waddr_q == LAST_ADDR);
  assign busy       = (byte_cnt != 2'd0) || (waddr_q != '0);
  assign resync     = (state != ST_FULL) && busy && !sample && (to_cnt == TO_LAST);
  assign swap       = (state == ST_FULL) && bus.swapped_ftdi;

  fb_byte_packer u_packer (
    .clk_60     (clk_60),
    .rst_n      (rst_n),
    .sample     (sample),
    .clear      (resync),
    .din        (bus.ftdi_data),
    .byte_cnt   (byte_cnt),
    .pixel_done (pixel_done),
    .we         (we),
    .wdata      (wdata)
  );

  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      oe_n_q <= 1'b1;
      rd_n_q <= 1'b1;
      full_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          oe_n_q <= 1'b1;
          rd_n_q <= 1'b1;
          if (!bus.rxf_n) begin
            oe_n_q <= 1'b0;
            state  <= ST_OE;
          end
        end
        ST_OE: begin
          rd_n_q <= 1'b0;
          state  <= ST_READ;
        end
        ST_READ: begin
          // frame end wins so the byte after the last pixel is never popped
          if (frame_done) begin
            rd_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            full_q <= 1'b1;
            state  <= ST_FULL;
          end else if (bus.rxf_n) begin
            rd_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_FULL: begin
          oe_n_q <= 1'b1;
          rd_n_q <= 1'b1;
          if (bus.swapped_ftdi) begin
            full_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address advances after each write; it parks at FRAME_PIXELS while FULL.
  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= '0;
    end else if (swap || resync) begin
      waddr_q <= '0;
    end else if (we) begin
      waddr_q <= waddr_q + FB_ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state != ST_FULL) begin
      if (sample || !busy || resync) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  assign bus.oe_n      = oe_n_q;
  assign bus.rd_n      = rd_n_q;
  assign bus.full_ftdi = full_q;
  assign bus.waddr     = waddr_q;
  assign bus.we        = we;
  assign bus.wdata     = wdata;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: FT232H FIFO source model, stream-level pixel model, directed scenarios.
module tb_fb_write_ctrl;
  import fb_write_ctrl_pkg::*;

  localparam int FP = 16384;
  localparam int TO = 100;

  logic clk_60 = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_60 = ~clk_60;

  fb_write_ctrl_if bus ();

  fb_write_ctrl #(.FRAME_PIXELS(FP), .IDLE_TIMEOUT(TO)) dut (
    .clk_60 (clk_60),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // FT232H receive FIFO: bytes leave the queue after an edge with rxf_n=0 and rd_n=0.
  byte unsigned src_q[$];
  bit src_en      = 1'b0;
  bit pop_pending = 1'b0;

  always @(posedge clk_60) begin
    #2;
    if (pop_pending && src_q.size() > 0) void'(src_q.pop_front());
    bus.rxf_n     = !(src_en && src_q.size() > 0);
    bus.ftdi_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  // Stream model: byte k of the stream belongs to pixel k/3; pixels land at consecutive addresses.
  int         nb, pix, idle;
  logic [7:0] b0, b1;
  bit         exp_we, exp_full, pop;
  logic [19:0] exp_wdata;
  int         exp_waddr;
  int         we_seen   = 0;
  int         last_waddr = 0;

  always @(negedge clk_60) begin
    if (!rst_n) begin
      nb = 0; pix = 0; idle = 0;
      exp_we = 1'b0; exp_full = 1'b0; pop_pending = 1'b0;
    end else begin
      chk("we", 32'(bus.we), 32'(exp_we));
      if (exp_we) begin
        chk("wdata", 32'(bus.wdata), 32'(exp_wdata));
        chk("waddr", 32'(bus.waddr), 32'(exp_waddr));
        we_seen++;
        last_waddr = int'(bus.waddr);
      end
      chk("full_ftdi", 32'(bus.full_ftdi), 32'(exp_full));
      if (exp_full) chk("rd_n_in_full", 32'(bus.rd_n), 32'd1);

      pop = !bus.rxf_n && !bus.rd_n;
      pop_pending = pop;
      exp_we = 1'b0;
      if (exp_full) begin
        if (bus.swapped_ftdi) begin
          exp_full = 1'b0;
          pix = 0;
        end
      end else if (pop) begin
        idle = 0;
        if (nb == 0) begin
          b0 = bus.ftdi_data; nb = 1;
        end else if (nb == 1) begin
          b1 = bus.ftdi_data; nb = 2;
        end else begin
          exp_wdata = {b0[3:0], b1, bus.ftdi_data};
          exp_waddr = pix;
          exp_we    = 1'b1;
          pix++;
          nb = 0;
          if (pix == FP) exp_full = 1'b1;
        end
      end else if (nb != 0 || pix != 0) begin
        idle++;
        if (idle == TO) begin
          nb = 0; pix = 0; idle = 0;
        end
      end else begin
        idle = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_60);
    #1;
  endtask

  task automatic wait_we(input string name, input int max_cyc,
                         output logic [19:0] d, output logic [14:0] a, output int n);
    d = '0; a = '0; n = 0;
    while (n < max_cyc) begin
      @(negedge clk_60);
      n++;
      if (bus.we) begin
        d = bus.wdata;
        a = bus.waddr;
        return;
      end
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk_60);
      if (src_q.size() == 0) return;
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oe_n"},  32'(bus.oe_n),      32'd1);
    chk({tag, "_rd_n"},  32'(bus.rd_n),      32'd1);
    chk({tag, "_we"},    32'(bus.we),        32'd0);
    chk({tag, "_wdata"}, 32'(bus.wdata),     32'd0);
    chk({tag, "_waddr"}, 32'(bus.waddr),     32'd0);
    chk({tag, "_full"},  32'(bus.full_ftdi), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] d;
    logic [14:0] a;
    int n, w0;
    bit got_full;

    bus.swapped_ftdi = 1'b0;
    cycles(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cycles(2);

    // Packing and first-pixel latency
    src_q.push_back(8'hA5); src_q.push_back(8'h3C); src_q.push_back(8'h7E);
    src_en = 1'b1;
    wait_we("pack", 20, d, a, n);
    chk("pack_wdata", 32'(d), 32'h53C7E);
    chk("pack_waddr", 32'(a), 32'd0);
    chk("pack_latency", 32'(n), 32'd6);
    @(negedge clk_60);
    chk("pack_waddr_inc", 32'(bus.waddr), 32'd1);

    // Starvation after byte 1, resume via OE
    @(posedge clk_60); #1;
    src_q.push_back(8'h12); src_q.push_back(8'h34);
    wait_drain("starve", 20);
    chk("starve_rd_still_low", 32'(bus.rd_n), 32'd0);
    @(negedge clk_60);
    chk("starve_rd_high", 32'(bus.rd_n), 32'd1);
    cycles(3);
    chk("starve_oe_idle", 32'(bus.oe_n), 32'd1);
    src_q.push_back(8'h56);
    wait_we("starve_pix", 20, d, a, n);
    chk("starve_wdata", 32'(d), 32'h23456);
    chk("starve_waddr", 32'(a), 32'd1);

    // Idle timeout discards a partial frame
    @(posedge clk_60); #1;
    src_q.push_back(8'h11); src_q.push_back(8'h22);
    src_q.push_back(8'h33); src_q.push_back(8'h44);
    wait_we("to_pix", 20, d, a, n);
    chk("to_pix_wdata", 32'(d), 32'h12233);
    chk("to_pix_waddr", 32'(a), 32'd2);
    wait_drain("to_drain", 20);
    cycles(TO + 5);
    chk("to_waddr_cleared", 32'(bus.waddr), 32'd0);
    src_q.push_back(8'h0F); src_q.push_back(8'hAB); src_q.push_back(8'hCD);
    wait_we("to_resume", 20, d, a, n);
    chk("to_resume_wdata", 32'(d), 32'hFABCD);
    chk("to_resume_waddr", 32'(a), 32'd0);

    // swapped_ftdi outside FULL is ignored
    @(posedge clk_60); #1;
    bus.swapped_ftdi = 1'b1;
    @(posedge clk_60); #1;
    bus.swapped_ftdi = 1'b0;
    cycles(1);
    chk("stray_swap_waddr", 32'(bus.waddr), 32'd1);
    chk("stray_swap_full", 32'(bus.full_ftdi), 32'd0);

    // Asynchronous reset in the middle of READ
    for (int k = 1; k <= 9; k++) src_q.push_back(8'(k));
    wait_we("rst_pix", 20, d, a, n);
    chk("rst_pix_wdata", 32'(d), 32'h10203);
    chk("rst_pix_waddr", 32'(a), 32'd1);
    @(posedge clk_60); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    src_q.delete();
    src_en = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // Full frame fill, plus one pixel queued behind it
    for (int i = 0; i < FP; i++) begin
      src_q.push_back(8'(i * 7 + 3));
      src_q.push_back(8'(i >> 3));
      src_q.push_back(8'(i * 13));
    end
    src_q.push_back(8'hE9); src_q.push_back(8'h87); src_q.push_back(8'h65);
    w0 = we_seen;
    src_en = 1'b1;
    got_full = 1'b0;
    for (int k = 0; k < 60000 && !got_full; k++) begin
      @(negedge clk_60);
      if (bus.full_ftdi) got_full = 1'b1;
    end
    chk("fill_full_reached", 32'(got_full), 32'd1);
    cycles(3);
    chk("fill_we_count", 32'(we_seen - w0), 32'(FP));
    chk("fill_last_waddr", 32'(last_waddr), 32'(FP - 1));
    chk("full_waddr_parked", 32'(bus.waddr), 32'(FP));
    chk("full_rd_n", 32'(bus.rd_n), 32'd1);
    chk("full_oe_n", 32'(bus.oe_n), 32'd1);
    chk("full_no_extra_pop", 32'(src_q.size()), 32'd3);

    // Swap handshake releases the FTDI
    bus.swapped_ftdi = 1'b1;
    @(posedge clk_60); #1;
    bus.swapped_ftdi = 1'b0;
    @(negedge clk_60);
    chk("swap_full_low", 32'(bus.full_ftdi), 32'd0);
    chk("swap_waddr_zero", 32'(bus.waddr), 32'd0);
    @(negedge clk_60);
    chk("swap_oe_low", 32'(bus.oe_n), 32'd0);
    wait_we("swap_pix", 20, d, a, n);
    chk("swap_pix_wdata", 32'(d), 32'h98765);
    chk("swap_pix_waddr", 32'(a), 32'd0);
    cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
